// File: rtl/mmio_router.sv
// MMIO router: decodes a CPU word address by tag into one of NUM_TARGETS ports and runs an IDLE/REQ/DONE handshake.
// Optional ack timeout is enabled by defining MMIO_ROUTER_TIMEOUT_EN.
module mmio_router #(
  parameter int NUM_TARGETS = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH = 4,
  parameter logic [NUM_TARGETS*TAG_WIDTH-1:0] TAG_MAP = {4'hf, 4'he, 4'hd, 4'hc},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_read_in,
  input  logic                      cpu_write_in,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [3:0]                cpu_byte_w_en,
  output logic [31:0]               cpu_rdata,
  output logic                      mem_stall,
  output logic                      cpu_err,
  output logic [NUM_TARGETS-1:0]    tgt_req,
  output logic                      tgt_write,
  output logic [ADDR_WIDTH-1:0]     tgt_addr,
  output logic [31:0]               tgt_wdata,
  output logic [3:0]                tgt_byte_w_en,
  input  logic [NUM_TARGETS-1:0]    tgt_ack,
  input  logic [NUM_TARGETS*32-1:0] tgt_rdata
);

  localparam int SEL_W = $clog2(NUM_TARGETS);
  localparam logic [NUM_TARGETS-1:0] ONE_HOT0 = 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] dec_sel;
  logic [TAG_WIDTH-1:0] tag;
  logic             active;
  logic             sel_ack;
  logic [31:0]      sel_rdata;

  assign tag       = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign active    = cpu_read_in | cpu_write_in;
  assign mem_stall = ~rst & active & (state != DONE);
  assign sel_ack   = tgt_ack[sel];
  assign sel_rdata = tgt_rdata[sel*32 +: 32];

  // Scan from the top down so the lowest matching entry wins; no match falls back to target 0.
  always_comb begin
    dec_sel = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (TAG_MAP[i*TAG_WIDTH +: TAG_WIDTH] == tag) dec_sel = SEL_W'(i);
    end
  end

`ifdef MMIO_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        err_q;
  assign cpu_err = err_q;
`else
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= '0;
      tgt_req       <= '0;
      tgt_write     <= 1'b0;
      tgt_addr      <= '0;
      tgt_wdata     <= '0;
      tgt_byte_w_en <= '0;
      cpu_rdata     <= '0;
`ifdef MMIO_ROUTER_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            tgt_write     <= cpu_write_in;
            tgt_addr      <= cpu_addr;
            tgt_wdata     <= cpu_wdata;
            tgt_byte_w_en <= cpu_byte_w_en;
            sel           <= dec_sel;
            tgt_req       <= ONE_HOT0 << dec_sel;
            state         <= REQ;
`ifdef MMIO_ROUTER_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        REQ: begin
          // An ack always beats a timeout in the same cycle; results of a dropped request are discarded.
          if (sel_ack) begin
            tgt_req <= '0;
            if (!tgt_write && active) cpu_rdata <= sel_rdata;
            state   <= DONE;
          end
`ifdef MMIO_ROUTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            tgt_req   <= '0;
            cpu_rdata <= 32'h0;
            err_q     <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
`ifdef MMIO_ROUTER_TIMEOUT_EN
          err_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
